// File: rtl/panel_row_loader_if.sv
// panel_row_loader_if
//   Bundles the two buses handled by the row loader:
//   - the byte stream from the network receive path (valid/ready/last),
//   - the single-cycle write bus into the HUB75 panel driver.
//
//   Signals:
//     in_data   [7:0]   stream byte
//     in_valid          in_data is valid
//     in_last           final byte of a packet (qualified by in_valid)
//     in_ready          loader accepts a byte when in_valid && in_ready
//     ctrl_en   [7:0]   target panel index during a write, idle code otherwise
//     ctrl_addr [15:0]  {4'b0, row[5:0], col[5:0]}
//     ctrl_wdat [16:0]  {1'b0, RGB565}
//
//   Modports:
//     master : upstream side (drives the stream, observes the write bus)
//     slave  : the loader (consumes the stream, drives the write bus)
interface panel_row_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  ctrl_en;
    logic [15:0] ctrl_addr;
    logic [16:0] ctrl_wdat;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready,
        input  ctrl_en,
        input  ctrl_addr,
        input  ctrl_wdat
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready,
        output ctrl_en,
        output ctrl_addr,
        output ctrl_wdat
    );
endinterface

// File: rtl/panel_row_loader.sv
// panel_row_loader
//   Upstream feeder for the 64x64 HUB75 panel driver's write port. Parses
//   130-byte row packets (panel, row, 64 little-endian RGB565 pixels) from a
//   byte stream and issues one write per pixel, one cycle after its high byte
//   is accepted. Malformed packets are counted and dropped up to in_last.
//
//   Ports:
//     display_clock        sole clock, shared with the panel driver
//     rst_n                asynchronous, active-low reset
//     bus (slave)          byte stream in, panel write bus out
//     row_done             1-cycle pulse with the 64th write of a good packet
//     frame_done           row_done for the bottom row (HEIGHT-1)
//     err_count [7:0]      malformed packet count, saturating at 255
module panel_row_loader #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned HEIGHT      = 64,
    parameter int unsigned PANEL_COUNT = 8,
    parameter logic [7:0]  IDLE_EN     = 8'hFF
) (
    input  logic              display_clock,
    input  logic              rst_n,
    panel_row_loader_if.slave bus,
    output logic              row_done,
    output logic              frame_done,
    output logic [7:0]        err_count
);

    typedef enum logic [2:0] {
        HDR_PANEL,
        HDR_ROW,
        PIX_LO,
        PIX_HI,
        DROP
    } state_t;

    // Header bytes are compared one bit wider so the limits never truncate.
    localparam logic [8:0] PANEL_LIMIT = 9'(PANEL_COUNT);
    localparam logic [8:0] ROW_LIMIT   = 9'(HEIGHT);
    localparam logic [5:0] LAST_COL    = 6'(WIDTH - 1);
    localparam logic [5:0] LAST_ROW    = 6'(HEIGHT - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  panel_q;
    logic [5:0]  row_q;
    logic [5:0]  col_q;
    logic [7:0]  lo_q;

    logic        accept;
    logic        latch_panel;
    logic        latch_row;
    logic        latch_lo;
    logic        col_inc;
    logic        do_write;
    logic        do_row_done;
    logic        do_err;

    assign accept = bus.in_valid && bus.in_ready;

    // Next-state and per-byte actions. Nothing moves without an accepted
    // byte, so gaps in in_valid simply hold state and the partial pixel.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a value unassigned (which would infer a latch).
        state_next  = state;
        latch_panel = 1'b0;
        latch_row   = 1'b0;
        latch_lo    = 1'b0;
        col_inc     = 1'b0;
        do_write    = 1'b0;
        do_row_done = 1'b0;
        do_err      = 1'b0;

        if (accept) begin
            case (state)
                HDR_PANEL: begin
                    latch_panel = 1'b1;
                    if (bus.in_last || ({1'b0, bus.in_data} >= PANEL_LIMIT)) begin
                        do_err     = 1'b1;
                        state_next = bus.in_last ? HDR_PANEL : DROP;
                    end else begin
                        state_next = HDR_ROW;
                    end
                end
                HDR_ROW: begin
                    latch_row = 1'b1;
                    if (bus.in_last || ({1'b0, bus.in_data} >= ROW_LIMIT)) begin
                        do_err     = 1'b1;
                        state_next = bus.in_last ? HDR_PANEL : DROP;
                    end else begin
                        state_next = PIX_LO;
                    end
                end
                PIX_LO: begin
                    latch_lo = 1'b1;
                    if (bus.in_last) begin
                        do_err     = 1'b1;
                        state_next = HDR_PANEL;
                    end else begin
                        state_next = PIX_HI;
                    end
                end
                PIX_HI: begin
                    // The pixel is written regardless of how the packet ends;
                    // writes already issued for a short packet stand.
                    do_write = 1'b1;
                    if (col_q != LAST_COL) begin
                        if (bus.in_last) begin
                            do_err     = 1'b1;
                            state_next = HDR_PANEL;
                        end else begin
                            col_inc    = 1'b1;
                            state_next = PIX_LO;
                        end
                    end else if (bus.in_last) begin
                        do_row_done = 1'b1;
                        state_next  = HDR_PANEL;
                    end else begin
                        do_err     = 1'b1;
                        state_next = DROP;
                    end
                end
                DROP: begin
                    if (bus.in_last) begin
                        state_next = HDR_PANEL;
                    end
                end
                default: state_next = HDR_PANEL;
            endcase
        end
    end

    always_ff @(posedge display_clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= HDR_PANEL;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its inputs.
            state <= state_next;
        end
    end

    // Datapath and registered outputs. The write bus is registered, which
    // places each write exactly one cycle after its high byte is accepted.
    always_ff @(posedge display_clock or negedge rst_n) begin
        if (!rst_n) begin
            bus.in_ready  <= 1'b0;
            bus.ctrl_en   <= IDLE_EN;
            bus.ctrl_addr <= '0;
            bus.ctrl_wdat <= '0;
            row_done      <= 1'b0;
            frame_done    <= 1'b0;
            err_count     <= '0;
            panel_q       <= '0;
            row_q         <= '0;
            col_q         <= '0;
            lo_q          <= '0;
        end else begin
            // The loader never back-pressures once out of reset.
            bus.in_ready <= 1'b1;
            bus.ctrl_en  <= IDLE_EN;
            row_done     <= 1'b0;
            frame_done   <= 1'b0;

            if (latch_panel) begin
                panel_q <= bus.in_data;
            end
            if (latch_row) begin
                row_q <= bus.in_data[5:0];
                col_q <= '0;
            end
            if (latch_lo) begin
                lo_q <= bus.in_data;
            end
            if (col_inc) begin
                col_q <= col_q + 6'd1;
            end

            // ctrl_addr/ctrl_wdat are only loaded on a write and otherwise
            // keep their last values.
            if (do_write) begin
                bus.ctrl_en   <= panel_q;
                bus.ctrl_addr <= {4'b0000, row_q, col_q};
                bus.ctrl_wdat <= {1'b0, bus.in_data, lo_q};
            end

            if (do_row_done) begin
                row_done   <= 1'b1;
                frame_done <= (row_q == LAST_ROW);
            end

            if (do_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
